arbitro_cajeros: RTL
====================

ARBITRO_CAJEROS -- requirements
Module: arbitro_cajeros

Interface
REQ-001 Parameter N_CAJEROS, default 4: number of ATM front-ends sharing one account balance.
REQ-002 Parameter W_MONTO, default 32: transaction amount width.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  N_CAJEROS  per-ATM transaction request, held high until that ATM's done pulse.
REQ-006 req_tipo  input  N_CAJEROS  per-ATM type: 0 = deposit, 1 = withdrawal.
REQ-007 req_monto  input  N_CAJEROS*W_MONTO  per-ATM amount, ATM i in bits [i*W_MONTO +: W_MONTO].
REQ-008 bal_load  input  1  load request for the shared balance.
REQ-009 bal_init  input  64  value loaded by bal_load.
REQ-010 gnt  output  N_CAJEROS  one-hot grant, high from ARB through RESP.
REQ-011 done  output  N_CAJEROS  one-cycle one-hot completion pulse.
REQ-012 resp_ok  output  1  transaction applied, valid while done is nonzero.
REQ-013 resp_cod  output  2  00 ok, 01 insufficient funds, 10 deposit overflow; valid with done.
REQ-014 saldo  output  64  current shared balance, registered.
REQ-015 tx_cnt  output  16  count of applied transactions.
REQ-016 ocupado  output  1  high whenever the FSM is not in IDLE.
REQ-017 estado_actual  output  3  debug copy of the FSM state.

Function
REQ-018 FSM states SHALL be IDLE=0, ARB=1, EVAL=2, ACT=3 and RESP=4; no other encodings reachable.
REQ-019 In IDLE, when bal_load=1, saldo SHALL load bal_init at the next edge, FSM SHALL stay in IDLE, and req_valid SHALL be ignored that cycle.
REQ-020 In IDLE, when bal_load=0 and any req_valid=1, the FSM SHALL go to ARB and latch the winner index, its tipo and its monto.
REQ-021 The winner SHALL be chosen round-robin: the first requesting index at or after the pointer, wrapping modulo N_CAJEROS.
REQ-022 The pointer SHALL reset to 0 and, on each RESP exit, SHALL advance to winner+1, wrapping from N_CAJEROS-1 to 0.
REQ-023 ARB->EVAL unconditionally; EVAL SHALL register the result code.
- Withdrawal with monto > saldo gives 01.
- Deposit where saldo + monto exceeds 2^64-1 gives 10.
- Otherwise 00.
REQ-024 EVAL->ACT unconditionally. In ACT, when the code is 00, saldo SHALL update: minus monto for a withdrawal, plus monto for a deposit; monto is zero-extended to 64 bits.
REQ-025 In ACT with code 00, tx_cnt SHALL increment at the same edge, wrapping from 0xFFFF to 0.
REQ-026 ACT->RESP unconditionally.
- In RESP, done[winner]=1, resp_ok = (code==00) and resp_cod = code, for exactly one cycle.
- RESP->IDLE.
REQ-027 Latency from a request sampled in IDLE to its done pulse SHALL be exactly 4 cycles.
- Back-to-back grants are separated by at least one IDLE cycle.
REQ-028 req_valid, req_tipo and req_monto changes after the ARB latch SHALL NOT affect the running transaction.
REQ-029 bal_load asserted outside IDLE SHALL be ignored and SHALL NOT be queued.
REQ-030 A zero-amount transaction SHALL complete with code 00, leave saldo unchanged and increment tx_cnt.
REQ-031 Outside RESP, done SHALL be 0, resp_ok 0 and resp_cod 00. Outside ARB..RESP, gnt SHALL be 0.

Reset
REQ-032 reset low SHALL immediately force:
- state IDLE, pointer 0;
- saldo 0, tx_cnt 0;
- gnt 0, done 0, resp_ok 0, resp_cod 00, ocupado 0.
REQ-033 Reset mid-transaction SHALL abandon the transaction with no done pulse and no balance change beyond what had already been written.
REQ-034 Release of reset SHALL be synchronised so the FSM leaves IDLE no earlier than the second rising edge after deassertion.

Structure
REQ-035 A shared package arbitro_pkg SHALL hold:
- the state encodings;
- the resp_cod values;
- the default N_CAJEROS and W_MONTO values.
REQ-036 The round-robin selection SHALL be a combinational sub-module rr_selector (inputs: request vector and pointer; outputs: one-hot grant and winner index).

Verification
REQ-037 Load and single withdrawal: bal_load with 1000, then ATM0 withdraws 300 -> done[0] 4 cycles later, resp_ok=1, saldo=700, tx_cnt=1.
REQ-038 Insufficient funds: saldo=100, ATM2 withdraws 101 -> done[2], resp_cod=01, saldo stays 100, tx_cnt unchanged.
REQ-039 Simultaneous requests: all four ATMs request together from pointer 0 -> grant order 0,1,2,3, each done 5 cycles apart; then ATM3 and ATM0 request -> ATM0 served first (wrap).
REQ-040 Overflow: saldo=0xFFFF_FFFF_FFFF_FFF0, ATM1 deposits 0x20 -> resp_cod=10, saldo unchanged.
REQ-041 Mid-operation: assert reset during EVAL -> no done pulse, saldo=0; bal_load asserted during ACT -> ignored, saldo takes the transaction result only.

Source files
------------

// File: rtl/arbitro_pkg.sv
// Shared constants for the ATM balance arbiter: FSM encodings, response codes
// and default sizing.
package arbitro_pkg;

    localparam int N_CAJEROS_DEF = 4;
    localparam int W_MONTO_DEF   = 32;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_ARB  = 3'd1;
    localparam logic [2:0] ST_EVAL = 3'd2;
    localparam logic [2:0] ST_ACT  = 3'd3;
    localparam logic [2:0] ST_RESP = 3'd4;

    localparam logic [1:0] COD_OK         = 2'b00;
    localparam logic [1:0] COD_SIN_FONDOS = 2'b01;
    localparam logic [1:0] COD_DESBORDE   = 2'b10;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/arbitro_cajeros_rr_selector.sv
// Combinational round-robin pick: first requester at or after the pointer,
// wrapping modulo N.
module rr_selector
    import arbitro_pkg::*;
#(
    parameter int N  = N_CAJEROS_DEF,
    parameter int IW = idx_width(N_CAJEROS_DEF)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);

    logic [IW:0] k;
    logic        found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        k     = '0;
        for (int i = 0; i < N; i++) begin
            k = {1'b0, ptr} + (IW+1)'(i);
            if (k >= (IW+1)'(N)) k = k - (IW+1)'(N);
            if (!found && req[k[IW-1:0]]) begin
                found           = 1'b1;
                gnt[k[IW-1:0]]  = 1'b1;
                idx             = k[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/arbitro_cajeros.sv
// Round-robin arbiter letting N ATM front-ends apply deposits/withdrawals to
// one shared 64-bit balance, one transaction at a time.
//
// state | meaning
// IDLE  | waiting; bal_load or a new request accepted here
// ARB   | winner index, type and amount latched
// EVAL  | result code computed and registered
// ACT   | balance and tx counter updated when code is ok
// RESP  | one-cycle done/resp pulse, pointer advanced
module arbitro_cajeros
    import arbitro_pkg::*;
#(
    parameter int N_CAJEROS = N_CAJEROS_DEF,
    parameter int W_MONTO   = W_MONTO_DEF
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [N_CAJEROS-1:0]          req_valid,
    input  logic [N_CAJEROS-1:0]          req_tipo,
    input  logic [N_CAJEROS*W_MONTO-1:0]  req_monto,
    input  logic                          bal_load,
    input  logic [63:0]                   bal_init,
    output logic [N_CAJEROS-1:0]          gnt,
    output logic [N_CAJEROS-1:0]          done,
    output logic                          resp_ok,
    output logic [1:0]                    resp_cod,
    output logic [63:0]                   saldo,
    output logic [15:0]                   tx_cnt,
    output logic                          ocupado,
    output logic [2:0]                    estado_actual
);

    localparam int IW = idx_width(N_CAJEROS);

    logic [1:0]           rst_sync;
    logic                 rst_n;
    logic [2:0]           estado;
    logic [IW-1:0]        ptr;
    logic [IW-1:0]        win_idx;
    logic [N_CAJEROS-1:0] win_gnt;
    logic                 win_tipo;
    logic [W_MONTO-1:0]   win_monto;
    logic [1:0]           cod;
    logic [1:0]           cod_next;
    logic [63:0]          monto64;
    logic [64:0]          suma;
    logic [N_CAJEROS-1:0] sel_gnt;
    logic [IW-1:0]        sel_idx;

    // Assertion is immediate; release reaches the FSM two edges later.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    rr_selector #(.N(N_CAJEROS), .IW(IW)) u_rr (
        .req (req_valid),
        .ptr (ptr),
        .gnt (sel_gnt),
        .idx (sel_idx)
    );

    assign monto64 = 64'(win_monto);
    assign suma    = {1'b0, saldo} + {1'b0, monto64};

    always_comb begin
        cod_next = COD_OK;
        if (win_tipo && (monto64 > saldo))  cod_next = COD_SIN_FONDOS;
        else if (!win_tipo && suma[64])     cod_next = COD_DESBORDE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado    <= ST_IDLE;
            ptr       <= '0;
            win_idx   <= '0;
            win_gnt   <= '0;
            win_tipo  <= 1'b0;
            win_monto <= '0;
            cod       <= COD_OK;
            saldo     <= '0;
            tx_cnt    <= '0;
        end else begin
            case (estado)
                ST_IDLE: begin
                    if (bal_load) begin
                        saldo <= bal_init;
                    end else if (|req_valid) begin
                        estado    <= ST_ARB;
                        win_idx   <= sel_idx;
                        win_gnt   <= sel_gnt;
                        win_tipo  <= req_tipo[sel_idx];
                        win_monto <= req_monto[sel_idx*W_MONTO +: W_MONTO];
                    end
                end
                ST_ARB:  estado <= ST_EVAL;
                ST_EVAL: begin
                    cod    <= cod_next;
                    estado <= ST_ACT;
                end
                ST_ACT: begin
                    if (cod == COD_OK) begin
                        saldo  <= win_tipo ? (saldo - monto64) : suma[63:0];
                        tx_cnt <= tx_cnt + 16'd1;
                    end
                    estado <= ST_RESP;
                end
                ST_RESP: begin
                    ptr    <= (win_idx == IW'(N_CAJEROS-1)) ? '0 : win_idx + IW'(1);
                    estado <= ST_IDLE;
                end
                default: estado <= ST_IDLE;
            endcase
        end
    end

    assign gnt           = (estado != ST_IDLE) ? win_gnt : '0;
    assign done          = (estado == ST_RESP) ? win_gnt : '0;
    assign resp_ok       = (estado == ST_RESP) && (cod == COD_OK);
    assign resp_cod      = (estado == ST_RESP) ? cod : COD_OK;
    assign ocupado       = (estado != ST_IDLE);
    assign estado_actual = estado;

endmodule
